cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between the execution units: load buffer, store buffer, branch unit, ALU, and the optional MULT/DIV/FPU/coprocessor units.
- Each cycle it grants at most one requesting unit using round-robin priority and latches that unit's `cdb_data_t` into one output register.
- It presents the register to the ROB and reservation stations with a valid/ready handshake.
- It sits between the EU output stages and the ROB/RS/register-status CDB inputs.

---
 rtl/cdb_arbiter.sv | 142 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// ---------------------------------------------------------------------------
// cdb_arbiter
//
// Purpose:
//   Shares the single common data bus (CDB) between the execution units.
//   Each cycle at most one requesting unit is granted using round-robin
//   priority. The granted unit's result is latched into one output register,
//   which is then offered to the ROB / reservation stations through a
//   valid/ready handshake.
//
// Ports:
//   clk_i        in   1              clock
//   rst_i        in   1              asynchronous active-high reset
//   flush_i      in   1              pipeline flush: drops held and incoming results
//   eu_valid_i   in   EU_N           per-unit result valid
//   eu_ready_o   out  EU_N           per-unit grant, one-hot or zero
//   eu_data_i    in   EU_N x cdb_data_t  per-unit result
//   cdb_valid_o  out  1              output register holds valid data
//   cdb_ready_i  in   1              ROB accepts the CDB data this cycle
//   cdb_data_o   out  cdb_data_t     output register contents
//   cdb_src_o    out  SRC_W          index of the unit that produced cdb_data_o
// ---------------------------------------------------------------------------

package expipe_pkg;
    localparam int EU_N      = 4;
    localparam int ROB_IDX_W = 5;
    localparam int DATA_W    = 64;
    localparam int EXC_W     = 5;
    localparam int FLAGS_W   = 4;

    typedef struct packed {
        logic [ROB_IDX_W-1:0] rob_idx;
        logic [DATA_W-1:0]    res_value;
        logic                 except_raised;
        logic [EXC_W-1:0]     except_code;
        logic [FLAGS_W-1:0]   flags;
    } cdb_data_t;
endpackage

module cdb_arbiter #(
    parameter int EU_N  = expipe_pkg::EU_N,
    parameter int SRC_W = $clog2(EU_N)
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               flush_i,
    input  logic [EU_N-1:0]                    eu_valid_i,
    output logic [EU_N-1:0]                    eu_ready_o,
    input  expipe_pkg::cdb_data_t [EU_N-1:0]   eu_data_i,
    output logic                               cdb_valid_o,
    input  logic                               cdb_ready_i,
    output expipe_pkg::cdb_data_t              cdb_data_o,
    output logic [SRC_W-1:0]                   cdb_src_o
);

    localparam logic [SRC_W:0] EU_N_X = (SRC_W+1)'(EU_N);

    // (base + off) mod EU_N for base < EU_N and off < EU_N; one extra bit
    // of headroom is enough, so a single conditional subtract wraps it.
    function automatic logic [SRC_W-1:0] wrap_add(input logic [SRC_W-1:0] base,
                                                  input logic [SRC_W:0]   off);
        logic [SRC_W:0] sum;
        sum = {1'b0, base} + off;
        if (sum >= EU_N_X) begin
            sum = sum - EU_N_X;
        end
        return sum[SRC_W-1:0];
    endfunction

    logic                   r_vld_p0;
    expipe_pkg::cdb_data_t  r_data_p0;
    logic [SRC_W-1:0]       r_src_p0;
    logic [SRC_W-1:0]       r_rr;

    logic                   w_free;
    logic                   w_arb_en;
    logic                   w_found;
    logic                   w_grant;
    logic [SRC_W-1:0]       w_win;
    logic [SRC_W-1:0]       w_idx;

    // ---- Arbitration (combinational, same cycle as request) ----
    // The register is free when empty or being drained this cycle, which
    // lets a drain and a new capture share one edge (1 result/cycle).
    // The grant never looks at the winner's own ready, so no loop forms.
    always_comb begin
        w_free   = !r_vld_p0 || cdb_ready_i;
        w_arb_en = w_free && !flush_i && !rst_i;
        w_found  = 1'b0;
        w_win    = '0;
        w_idx    = '0;
        for (int i = 0; i < EU_N; i++) begin
            w_idx = wrap_add(r_rr, (SRC_W+1)'(i));
            if (!w_found && eu_valid_i[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
        w_grant = w_arb_en && w_found;
    end

    always_comb begin
        eu_ready_o = '0;
        for (int k = 0; k < EU_N; k++) begin
            eu_ready_o[k] = w_grant && (w_win == SRC_W'(k));
        end
    end

    // ---- Output register stage p0 ----
    // Flush only clears valid; the pointer moves only on a real grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_p0  <= 1'b0;
            r_data_p0 <= '0;
            r_src_p0  <= '0;
            r_rr      <= '0;
        end else if (flush_i) begin
            r_vld_p0  <= 1'b0;
        end else if (w_grant) begin
            r_vld_p0  <= 1'b1;
            r_data_p0 <= eu_data_i[w_win];
            r_src_p0  <= w_win;
            r_rr      <= wrap_add(w_win, (SRC_W+1)'(1));
        end else if (w_free) begin
            r_vld_p0  <= 1'b0;
        end
    end

    assign cdb_valid_o = r_vld_p0;
    assign cdb_data_o  = r_data_p0;
    assign cdb_src_o   = r_src_p0;

    a_ready_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(eu_ready_o));

    a_ready_needs_valid : assert property (@(posedge clk_i) disable iff (rst_i)
        ((eu_ready_o & ~eu_valid_i) == '0));

    a_data_stable_on_stall : assert property (@(posedge clk_i) disable iff (rst_i)
        (cdb_valid_o && !cdb_ready_i) |=> $stable(cdb_data_o));

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
    import expipe_pkg::*;

    localparam int N  = 4;
    localparam int SW = 2;

    logic                   clk_i = 1'b0;
    logic                   rst_i;
    logic                   flush_i;
    logic [N-1:0]           eu_valid_i;
    logic [N-1:0]           eu_ready_o;
    cdb_data_t [N-1:0]      eu_data_i;
    logic                   cdb_valid_o;
    logic                   cdb_ready_i;
    cdb_data_t              cdb_data_o;
    logic [SW-1:0]          cdb_src_o;

    cdb_arbiter #(.EU_N(N), .SRC_W(SW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (flush_i),
        .eu_valid_i  (eu_valid_i),
        .eu_ready_o  (eu_ready_o),
        .eu_data_i   (eu_data_i),
        .cdb_valid_o (cdb_valid_o),
        .cdb_ready_i (cdb_ready_i),
        .cdb_data_o  (cdb_data_o),
        .cdb_src_o   (cdb_src_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        cdb_data_t     d;
        logic [SW-1:0] src;
    } exp_t;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    // Reference model: round-robin pointer and whether a result is held.
    int   m_rr  = 0;
    bit   m_vld = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic cdb_data_t rand_data();
        cdb_data_t d;
        d.rob_idx       = 5'($urandom);
        d.res_value     = {$urandom, $urandom};
        d.except_raised = 1'($urandom);
        d.except_code   = 5'($urandom);
        d.flags         = 4'($urandom);
        return d;
    endfunction

    // Called at posedge+1: drive one cycle, check grant at negedge, advance
    // the model at the posedge and push the expected CDB word on a grant.
    task automatic step(input logic [N-1:0] v, input bit rdy, input bit fl, output int win);
        bit free;
        eu_valid_i  = v;
        cdb_ready_i = rdy;
        flush_i     = fl;
        free = !m_vld || rdy;
        win  = -1;
        if (free && !fl) begin
            for (int i = 0; i < N; i++) begin
                if (win < 0 && v[(m_rr + i) % N]) win = (m_rr + i) % N;
            end
        end
        @(negedge clk_i);
        check("eu_ready", eu_ready_o, (win < 0) ? 0 : (1 << win));
        check("cdb_valid", cdb_valid_o, m_vld);
        @(posedge clk_i);
        if (fl) begin
            if (m_vld && !rdy && sb.size() > 0) void'(sb.pop_back());
            m_vld = 0;
        end else if (win >= 0) begin
            sb.push_back({eu_data_i[win], SW'(win)});
            m_vld = 1;
            m_rr  = (win + 1) % N;
        end else if (free) begin
            m_vld = 0;
        end
        #1;
    endtask

    // Scoreboard monitor: every accepted CDB transfer must match the oldest
    // expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (rst_i === 1'b0 && cdb_valid_o && cdb_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected: got src=%0d, expected no transfer", cdb_src_o);
                end else begin
                    e = sb.pop_front();
                    check("sb_data", cdb_data_o, e.d);
                    check("sb_src", cdb_src_o, e.src);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int        w;
        cdb_data_t d1;
        logic [N-1:0] pend;

        rst_i       = 1'b1;
        flush_i     = 1'b0;
        cdb_ready_i = 1'b0;
        eu_valid_i  = '1;
        for (int k = 0; k < N; k++) eu_data_i[k] = rand_data();
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_ready", eu_ready_o, 0);
        check("rst_valid", cdb_valid_o, 0);
        check("rst_src", cdb_src_o, 0);
        check("rst_data", cdb_data_o, 0);
        rst_i = 1'b0;

        // Single requester: unit 2, rob_idx 5, value DEAD.
        eu_data_i[2] = rand_data();
        eu_data_i[2].rob_idx   = 5'd5;
        eu_data_i[2].res_value = 64'hDEAD;
        step(4'b0100, 1'b1, 1'b0, w);
        check("single_valid", cdb_valid_o, 1);
        check("single_rob", cdb_data_o.rob_idx, 5);
        check("single_value", cdb_data_o.res_value, 64'hDEAD);
        check("single_src", cdb_src_o, 2);
        // Pointer is now 3: with everyone asking, unit 3 goes first.
        step(4'b1111, 1'b1, 1'b0, w);
        check("after_single_src", cdb_src_o, 3);

        // Reset asserted mid-cycle while holding data and with requests up.
        eu_valid_i  = '1;
        cdb_ready_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("midrst_valid", cdb_valid_o, 0);
        check("midrst_ready", eu_ready_o, 0);
        check("midrst_src", cdb_src_o, 0);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        m_vld = 0;
        m_rr  = 0;
        sb.delete();

        // Idle for 10 cycles.
        repeat (10) step('0, 1'b1, 1'b0, w);
        check("idle_src", cdb_src_o, 0);

        // Round robin with all four requesting: 0,1,2,3,0.
        for (int k = 0; k < N; k++) eu_data_i[k] = rand_data();
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b1, 1'b0, w);
            check("rr_valid", cdb_valid_o, 1);
            check("rr_src", cdb_src_o, i % N);
        end

        // Backpressure: unit 1 granted, then 3 stalled cycles with unit 3 asking.
        eu_data_i[1] = rand_data();
        d1 = eu_data_i[1];
        step(4'b0010, 1'b1, 1'b0, w);
        check("bp_src1", cdb_src_o, 1);
        eu_data_i[3] = rand_data();
        for (int i = 0; i < 3; i++) begin
            step(4'b1000, 1'b0, 1'b0, w);
            check("bp_hold_data", cdb_data_o, d1);
            check("bp_hold_src", cdb_src_o, 1);
        end
        step(4'b1000, 1'b1, 1'b0, w);
        check("bp_src3", cdb_src_o, 3);

        // Flush while stalled with units 0 and 2 valid; pointer stays at 0.
        step(4'b0101, 1'b0, 1'b0, w);
        step(4'b0101, 1'b0, 1'b1, w);
        check("flush_valid", cdb_valid_o, 0);
        step(4'b0101, 1'b1, 1'b0, w);
        check("flush_next_src", cdb_src_o, 0);

        // Wrap: pointer to 3, then 4'b1001 grants 3 and then 0.
        step(4'b0100, 1'b1, 1'b0, w);
        check("wrap_pre_src", cdb_src_o, 2);
        step(4'b1001, 1'b1, 1'b0, w);
        check("wrap_src3", cdb_src_o, 3);
        step(4'b1001, 1'b1, 1'b0, w);
        check("wrap_src0", cdb_src_o, 0);

        // Random traffic: requests held until granted, random backpressure and flush.
        pend = '0;
        for (int c = 0; c < 2000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && ($urandom_range(1, 0) == 1)) begin
                    pend[k]      = 1'b1;
                    eu_data_i[k] = rand_data();
                end
            end
            step(pend, ($urandom_range(3, 0) != 0), ($urandom_range(31, 0) == 0), w);
            if (w >= 0) pend[w] = 1'b0;
        end

        // Drain and make sure nothing expected is left behind.
        repeat (3) step('0, 1'b1, 1'b0, w);
        check("sb_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
